// File: rtl/fifo_pkg.sv
// Shared sizing helpers, parameter legality checks and status-flag bundle for the level FIFO.
package fifo_pkg;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int ptr_width(input int size);
    return clogb2(size) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int size, input int af_lvl, input int ae_lvl);
    return is_pow2(size) && (af_lvl >= 1) && (af_lvl <= size) &&
           (ae_lvl >= 0) && (ae_lvl < size);
  endfunction

  typedef struct packed {
    logic full;
    logic valid;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, valid: 1'b0, afull: 1'b0, aempty: 1'b1};

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port memory: synchronous write port, asynchronous read port.
module fifo_sdp_ram
  import fifo_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      we,
  input  logic [clogb2(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [clogb2(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]          rdata
);

  // Power-up contents are zero; reset never touches the array.
  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds and synchronous flush.
// Sticky overflow/underflow flags are added when FIFO_ERROR_FLAGS_EN is defined.
module sync_fifo_level
  import fifo_pkg::*;
#(
  parameter int BUFFER_SIZE        = 128,
  parameter int DATA_WIDTH         = 32,
  parameter int ALMOST_FULL_LEVEL  = 120,
  parameter int ALMOST_EMPTY_LEVEL = 8
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_full,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ack,
  output logic [clogb2(BUFFER_SIZE):0]  level,
  output logic                          almost_full,
  output logic                          almost_empty
`ifdef FIFO_ERROR_FLAGS_EN
  ,
  output logic                          overflow_error,
  output logic                          underflow_error
`endif
);

  localparam int AW = clogb2(BUFFER_SIZE);
  localparam int LW = ptr_width(BUFFER_SIZE);
  localparam logic [LW-1:0] FULL_LVL = LW'(BUFFER_SIZE);
  localparam logic [LW-1:0] AF_LVL   = LW'(ALMOST_FULL_LEVEL);
  localparam logic [LW-1:0] AE_LVL   = LW'(ALMOST_EMPTY_LEVEL);

  if (!params_ok(BUFFER_SIZE, ALMOST_FULL_LEVEL, ALMOST_EMPTY_LEVEL)) begin : g_bad_params
    $error("sync_fifo_level: illegal BUFFER_SIZE or threshold parameters");
  end

  logic [LW-1:0] wr_ptr, rd_ptr, level_nxt;
  logic          wr_en, rd_en;
  fifo_flags_t   flags;

  // Handshakes qualify on the registered flags, so a full FIFO refuses a
  // write even when a read frees a slot on the same edge.
  assign wr_en = data_in_valid && !flags.full  && !flush;
  assign rd_en = data_out_ack  &&  flags.valid && !flush;

  always_comb begin
    level_nxt = level;
    if (flush)                level_nxt = '0;
    else if (wr_en && !rd_en) level_nxt = level + LW'(1);
    else if (rd_en && !wr_en) level_nxt = level - LW'(1);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      flags  <= FLAGS_RST;
    end else begin
      level        <= level_nxt;
      flags.full   <= (level_nxt == FULL_LVL);
      flags.valid  <= (level_nxt != '0);
      flags.afull  <= (level_nxt >= AF_LVL);
      flags.aempty <= (level_nxt <= AE_LVL);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + LW'(1);
        if (rd_en) rd_ptr <= rd_ptr + LW'(1);
      end
    end
  end

  fifo_sdp_ram #(
    .DEPTH (BUFFER_SIZE),
    .WIDTH (DATA_WIDTH)
  ) u_ram (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (data_out)
  );

  assign data_in_full   = flags.full;
  assign data_out_valid = flags.valid;
  assign almost_full    = flags.afull;
  assign almost_empty   = flags.aempty;

`ifdef FIFO_ERROR_FLAGS_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      overflow_error  <= 1'b0;
      underflow_error <= 1'b0;
    end else if (flush) begin
      overflow_error  <= 1'b0;
      underflow_error <= 1'b0;
    end else begin
      if (data_in_valid && flags.full)  overflow_error  <= 1'b1;
      if (data_out_ack  && !flags.valid) underflow_error <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_level.sv
// Directed bench for sync_fifo_level at depth 8, width 16, thresholds 6/1.
module tb_sync_fifo_level;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] data_in;
  logic        data_in_valid;
  logic        data_in_full;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        data_out_ack;
  logic [3:0]  level;
  logic        almost_full;
  logic        almost_empty;
`ifdef FIFO_ERROR_FLAGS_EN
  logic        overflow_error;
  logic        underflow_error;
`endif

  int checks = 0;
  int errors = 0;

  sync_fifo_level #(
    .BUFFER_SIZE        (8),
    .DATA_WIDTH         (16),
    .ALMOST_FULL_LEVEL  (6),
    .ALMOST_EMPTY_LEVEL (1)
  ) dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .flush          (flush),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_full   (data_in_full),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ack   (data_out_ack),
    .level          (level),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty)
`ifdef FIFO_ERROR_FLAGS_EN
    ,
    .overflow_error (overflow_error),
    .underflow_error(underflow_error)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; data_in = '0; data_in_valid = 1'b0; data_out_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({level, data_out_valid, almost_empty, data_in_full, almost_full} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: level=%0d dv=%b ae=%b full=%b af=%b, want 0 0 1 0 0",
               level, data_out_valid, almost_empty, data_in_full, almost_full);
    end
`ifdef FIFO_ERROR_FLAGS_EN
    checks++;
    if ({overflow_error, underflow_error} !== 2'b00) begin
      errors++;
      $display("FAIL reset_err: ovf=%b udf=%b, want 0 0", overflow_error, underflow_error);
    end
`endif
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      data_in = 16'(i); data_in_valid = 1'b1;
      tick();
      checks++;
      if ({level, data_out_valid, almost_empty, almost_full, data_in_full} !==
          {4'(i), 1'b1, (i <= 1), (i >= 6), (i == 8)}) begin
        errors++;
        $display("FAIL fill_%0d: level=%0d dv=%b ae=%b af=%b full=%b, want %0d 1 %b %b %b",
                 i, level, data_out_valid, almost_empty, almost_full, data_in_full,
                 i, (i <= 1), (i >= 6), (i == 8));
      end
    end
    data_in = 16'h0009;
    tick();
    data_in_valid = 1'b0;
    checks++;
    if ({level, data_in_full} !== {4'd8, 1'b1}) begin
      errors++;
      $display("FAIL overfill: level=%0d full=%b, want 8 1", level, data_in_full);
    end
`ifdef FIFO_ERROR_FLAGS_EN
    checks++;
    if (overflow_error !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: got %b want 1", overflow_error);
    end
`endif
  endtask

  task automatic test_drain();
    data_out_ack = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (data_out !== 16'(i)) begin
        errors++;
        $display("FAIL drain_data_%0d: got %h want %h", i, data_out, 16'(i));
      end
      tick();
      checks++;
      if ({level, data_in_full} !== {4'(8 - i), 1'b0}) begin
        errors++;
        $display("FAIL drain_level_%0d: level=%0d full=%b, want %0d 0", i, level, data_in_full, 8 - i);
      end
    end
    // One more ack while empty must be ignored.
    tick();
    data_out_ack = 1'b0;
    checks++;
    if ({level, data_out_valid, almost_empty} !== {4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL drain_empty: level=%0d dv=%b ae=%b, want 0 0 1", level, data_out_valid, almost_empty);
    end
`ifdef FIFO_ERROR_FLAGS_EN
    checks++;
    if (underflow_error !== 1'b1) begin
      errors++;
      $display("FAIL underflow_flag: got %b want 1", underflow_error);
    end
`endif
  endtask

  task automatic test_simultaneous();
    data_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_in = 16'h0100 + 16'(k);
      tick();
    end
    data_out_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_in = 16'h0104 + 16'(i);
      checks++;
      if (data_out !== 16'h0100 + 16'(i)) begin
        errors++;
        $display("FAIL simul_data_%0d: got %h want %h", i, data_out, 16'h0100 + 16'(i));
      end
      tick();
      checks++;
      if (level !== 4'd4) begin
        errors++;
        $display("FAIL simul_level_%0d: got %0d want 4", i, level);
      end
    end
    data_out_ack = 1'b0;
    data_in = 16'h0200;
    tick();
    data_in_valid = 1'b0;
    checks++;
    if ({level, data_out} !== {4'd5, 16'h0114}) begin
      errors++;
      $display("FAIL simul_tail: level=%0d head=%h, want 5 0114", level, data_out);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; data_in_valid = 1'b1; data_out_ack = 1'b1; data_in = 16'hDEAD;
    tick();
    flush = 1'b0; data_in_valid = 1'b0; data_out_ack = 1'b0;
    checks++;
    if ({level, data_out_valid, almost_empty, almost_full, data_in_full} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL flush_state: level=%0d dv=%b ae=%b af=%b full=%b, want 0 0 1 0 0",
               level, data_out_valid, almost_empty, almost_full, data_in_full);
    end
`ifdef FIFO_ERROR_FLAGS_EN
    checks++;
    if ({overflow_error, underflow_error} !== 2'b00) begin
      errors++;
      $display("FAIL flush_err: ovf=%b udf=%b, want 0 0", overflow_error, underflow_error);
    end
`endif
    data_in = 16'h0055; data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    checks++;
    if ({level, data_out_valid, data_out} !== {4'd1, 1'b1, 16'h0055}) begin
      errors++;
      $display("FAIL flush_refill: level=%0d dv=%b data=%h, want 1 1 0055", level, data_out_valid, data_out);
    end
  endtask

  task automatic test_async_reset();
    data_in_valid = 1'b1;
    data_in = 16'h0301; tick();
    data_in = 16'h0302; tick();
    checks++;
    if (level !== 4'd3) begin
      errors++;
      $display("FAIL burst_level: got %0d want 3", level);
    end
    data_in = 16'h0303;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({level, data_out_valid, almost_empty, data_in_full, almost_full} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: level=%0d dv=%b ae=%b full=%b af=%b, want 0 0 1 0 0",
               level, data_out_valid, almost_empty, data_in_full, almost_full);
    end
    data_in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    data_in = 16'hBEEF; data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    checks++;
    if ({level, data_out_valid, data_out} !== {4'd1, 1'b1, 16'hBEEF}) begin
      errors++;
      $display("FAIL post_reset_read: level=%0d dv=%b data=%h, want 1 1 beef", level, data_out_valid, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
